// File: rtl/amp_trig_pkg.sv
// Shared types and constants for the amplifier trigger scheduler.
package amp_trig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUN     = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam int BLK_SIZE_DEF = 26;
    localparam int DLY_W_DEF    = 7;
    localparam int MISSED_W     = 8;
    localparam int STRETCH_CYC  = 4;

    function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
        if (v == {MISSED_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(MISSED_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/amp_trig_sched_sync.sv
// trig_sync_edge: 2-FF synchroniser for an asynchronous trigger followed by a
// registered rising-edge detect; edge_o is high for exactly one clock.
module trig_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic edge_q,  edge_d;

    // Next-state for the synchroniser chain and edge register.
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        edge_d  = sync2_q & ~prev_q;
    end

    // Synchroniser and edge flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/amp_trig_sched.sv
// Multi-channel amplifier trigger scheduler: delayed per-channel pulses after
// each accepted trigger edge. Optional macro AMP_TRIG_STRETCH_EN widens pulses.
module amp_trig_sched
    import amp_trig_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int BLK_SIZE    = BLK_SIZE_DEF,
    parameter int DLY_W       = DLY_W_DEF,
    parameter int HOLDOFF_CYC = 64,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger_in,
    input  logic                arm,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DLY_W-1:0]    cfg_delay,
    input  logic                cfg_en,
    output logic [NUM_CH-1:0]   amp_trig,
    output logic                busy,
    output logic                seq_done,
    output logic [MISSED_W-1:0] missed_cnt
);

    localparam int BLK_W  = (BLK_SIZE > 1) ? $clog2(BLK_SIZE) : 1;
    localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);

    typedef logic [NUM_CH-1:0][DLY_W-1:0] dly_arr_t;

    state_e                state_q, state_d;
    logic [BLK_W-1:0]      blk_ctr_q, blk_ctr_d;
    logic [DLY_W-1:0]      mstr_ctr_q, mstr_ctr_d;
    logic [HOLD_W-1:0]     hold_ctr_q, hold_ctr_d;
    dly_arr_t              shadow_dly_q, shadow_dly_d;
    logic [NUM_CH-1:0]     shadow_en_q, shadow_en_d;
    dly_arr_t              active_dly_q, active_dly_d;
    logic [NUM_CH-1:0]     active_en_q, active_en_d;
    logic [MISSED_W-1:0]   missed_q, missed_d;
    logic [NUM_CH-1:0]     amp_trig_q, amp_trig_d;
    logic                  busy_q, busy_d;
    logic                  seq_done_q, seq_done_d;
    logic [NUM_CH-1:0]     pulse_s;
    logic                  done_now_s;
    logic                  edge_det_s;

    function automatic logic [DLY_W-1:0] max_en_dly(input dly_arr_t dly,
                                                   input logic [NUM_CH-1:0] en);
        logic [DLY_W-1:0] m;
        m = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (en[ch] && (dly[ch] > m)) begin
                m = dly[ch];
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    trig_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (trigger_in),
        .edge_o  (edge_det_s)
    );

    // Shadow writes in any state; active set tracks shadow until a sequence starts.
    always_comb begin
        shadow_dly_d = shadow_dly_q;
        shadow_en_d  = shadow_en_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (cfg_wr && (cfg_ch == CH_W'(ch))) begin
                shadow_dly_d[ch] = cfg_delay;
                shadow_en_d[ch]  = cfg_en;
            end else begin
                shadow_dly_d[ch] = shadow_dly_q[ch];
                shadow_en_d[ch]  = shadow_en_q[ch];
            end
        end
        if ((state_q == IDLE) || (state_q == ARMED)) begin
            active_dly_d = shadow_dly_q;
            active_en_d  = shadow_en_q;
        end else begin
            active_dly_d = active_dly_q;
            active_en_d  = active_en_q;
        end
    end

    // Sequencer next-state, block/master counters, holdoff and missed accounting.
    always_comb begin
        state_d    = state_q;
        blk_ctr_d  = blk_ctr_q;
        mstr_ctr_d = mstr_ctr_q;
        hold_ctr_d = hold_ctr_q;
        done_now_s = (state_q == RUN) && (blk_ctr_q == '0) &&
                     (mstr_ctr_q == max_en_dly(active_dly_q, active_en_q));
        case (state_q)
            IDLE: begin
                if (arm) state_d = ARMED;
                else     state_d = IDLE;
            end
            ARMED: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (edge_det_s) begin
                    state_d    = RUN;
                    blk_ctr_d  = '0;
                    mstr_ctr_d = '0;
                end else begin
                    state_d = ARMED;
                end
            end
            RUN: begin
                if (done_now_s) begin
                    state_d    = HOLDOFF;
                    hold_ctr_d = '0;
                end else if (blk_ctr_q == BLK_W'(BLK_SIZE - 1)) begin
                    blk_ctr_d  = '0;
                    mstr_ctr_d = mstr_ctr_q + DLY_W'(1);
                end else begin
                    blk_ctr_d = blk_ctr_q + BLK_W'(1);
                end
            end
            HOLDOFF: begin
                if (hold_ctr_q == HOLD_W'(HOLDOFF_CYC - 1)) begin
                    state_d = arm ? ARMED : IDLE;
                end else begin
                    hold_ctr_d = hold_ctr_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (edge_det_s && ((state_q == RUN) || (state_q == HOLDOFF))) begin
            missed_d = sat_inc(missed_q);
        end else begin
            missed_d = missed_q;
        end
    end

    // Outputs are registered, so they are decoded from next-state values to
    // land in the same cycle the counters reach the match.
    always_comb begin
        pulse_s    = '0;
        seq_done_d = 1'b0;
        busy_d     = (state_d == RUN) || (state_d == HOLDOFF);
        if ((state_d == RUN) && (blk_ctr_d == '0)) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pulse_s[ch] = active_en_d[ch] && (mstr_ctr_d == active_dly_d[ch]);
            end
            seq_done_d = (mstr_ctr_d == max_en_dly(active_dly_d, active_en_d));
        end else begin
            pulse_s    = '0;
            seq_done_d = 1'b0;
        end
    end

`ifdef AMP_TRIG_STRETCH_EN
    localparam int STR_W = $clog2(STRETCH_CYC);

    logic [NUM_CH-1:0][STR_W-1:0] str_ctr_q, str_ctr_d;

    // Each pulse reloads a per-channel hold counter that keeps the output high.
    always_comb begin
        str_ctr_d  = str_ctr_q;
        amp_trig_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (pulse_s[ch]) begin
                str_ctr_d[ch] = STR_W'(STRETCH_CYC - 1);
            end else if (str_ctr_q[ch] != '0) begin
                str_ctr_d[ch] = str_ctr_q[ch] - STR_W'(1);
            end else begin
                str_ctr_d[ch] = str_ctr_q[ch];
            end
            amp_trig_d[ch] = pulse_s[ch] | (str_ctr_q[ch] != '0);
        end
    end

    // Stretch counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            str_ctr_q <= '0;
        end else begin
            str_ctr_q <= str_ctr_d;
        end
    end

    // A stretch started on the final delay must finish inside HOLDOFF.
    assert property (@(posedge clk) disable iff (!rst_n) HOLDOFF_CYC >= STRETCH_CYC);
`else
    // Single-cycle pulses.
    always_comb begin
        amp_trig_d = pulse_s;
    end
`endif

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            blk_ctr_q    <= '0;
            mstr_ctr_q   <= '0;
            hold_ctr_q   <= '0;
            shadow_dly_q <= '0;
            shadow_en_q  <= '0;
            active_dly_q <= '0;
            active_en_q  <= '0;
            missed_q     <= '0;
            amp_trig_q   <= '0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_ctr_q    <= blk_ctr_d;
            mstr_ctr_q   <= mstr_ctr_d;
            hold_ctr_q   <= hold_ctr_d;
            shadow_dly_q <= shadow_dly_d;
            shadow_en_q  <= shadow_en_d;
            active_dly_q <= active_dly_d;
            active_en_q  <= active_en_d;
            missed_q     <= missed_d;
            amp_trig_q   <= amp_trig_d;
            busy_q       <= busy_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign amp_trig   = amp_trig_q;
    assign busy       = busy_q;
    assign seq_done   = seq_done_q;
    assign missed_cnt = missed_q;

endmodule

// File: tb/tb_amp_trig_sched.sv
// Scoreboard bench for amp_trig_sched: an event-level model predicts pulse
// cycles, busy windows and missed counts; a negedge monitor compares.
module tb_amp_trig_sched;

    localparam int NUM_CH = 4;
    localparam int BLK    = 26;
    localparam int HO     = 64;
`ifdef AMP_TRIG_STRETCH_EN
    localparam int PW = 4;
`else
    localparam int PW = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger_in = 1'b0;
    logic       arm = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [6:0] cfg_delay = 7'd0;
    logic       cfg_en = 1'b0;
    logic [3:0] amp_trig;
    logic       busy;
    logic       seq_done;
    logic [7:0] missed_cnt;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic       done;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  mdl_dly[NUM_CH];
    bit  mdl_en[NUM_CH];
    bit  mdl_arm = 1'b0;
    int  mdl_missed = 0;
    int  cur_bs = -10, cur_be = -10, prev_bs = -10, prev_be = -10;
    bit  chk_en = 1'b0;
    int  run_len[NUM_CH];
    logic [3:0] amp_prev = 4'd0;

    amp_trig_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger_in (trigger_in),
        .arm        (arm),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_en     (cfg_en),
        .amp_trig   (amp_trig),
        .busy       (busy),
        .seq_done   (seq_done),
        .missed_cnt (missed_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    // Reference model: a trigger edge in cycle e is missed inside a busy
    // window, ignored when disarmed, otherwise schedules one event per delay.
    task automatic model_fire(input int e);
        ev_t ev;
        int  maxd;
        bit  any;
        if (e >= cur_bs && e <= cur_be) begin
            if (mdl_missed < 255) mdl_missed++;
        end else if (mdl_arm) begin
            maxd = 0;
            any  = 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (mdl_en[ch]) begin
                    any = 1'b1;
                    if (mdl_dly[ch] > maxd) maxd = mdl_dly[ch];
                end
            end
            if (!any) begin
                ev.cyc = e + 1; ev.mask = 4'd0; ev.done = 1'b1;
                exp_q.push_back(ev);
            end else begin
                for (int d = 0; d <= maxd; d++) begin
                    ev.mask = 4'd0;
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (mdl_en[ch] && mdl_dly[ch] == d) ev.mask[ch] = 1'b1;
                    if (ev.mask != 4'd0) begin
                        ev.cyc  = e + 1 + d * BLK;
                        ev.done = (d == maxd);
                        exp_q.push_back(ev);
                    end
                end
            end
            prev_bs = cur_bs;
            prev_be = cur_be;
            cur_bs  = e + 1;
            cur_be  = e + 1 + maxd * BLK + HO;
        end
    endtask

    // Monitor: pops the scoreboard on each output event, checks busy every cycle.
    always @(negedge clk) begin
        logic [3:0] rise;
        ev_t        e;
        bit         busy_exp;
        if (chk_en) begin
            rise = amp_trig & ~amp_prev;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (amp_trig[ch]) run_len[ch]++;
                else if (run_len[ch] != 0) begin
                    chk("pulse_width", run_len[ch], PW);
                    run_len[ch] = 0;
                end
            end
            if (rise != 4'd0 || seq_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {rise, seq_done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_mask", rise, e.mask);
                    chk("event_done", seq_done, e.done);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_event", 0, {e.mask, e.done});
            end
            busy_exp = (cyc >= cur_bs && cyc <= cur_be) || (cyc >= prev_bs && cyc <= prev_be);
            chk("busy", busy, busy_exp);
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) run_len[ch] = 0;
        end
        amp_prev = amp_trig;
    end

    task automatic cfg(input int ch, input int d, input bit en);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_ch = ch[1:0]; cfg_delay = d[6:0]; cfg_en = en;
        mdl_dly[ch] = d; mdl_en[ch] = en;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    // Raises trigger_in; the synchroniser plus edge register put edge_det 3 cycles later.
    task automatic fire(output int e);
        @(negedge clk);
        trigger_in = 1'b1;
        e = cyc + 3;
        model_fire(e);
        repeat (2) @(negedge clk);
        trigger_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fire_at(input int target);
        int e;
        if (cyc <= target - 4) begin
            while (cyc < target - 4) @(negedge clk);
            fire(e);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < limit);
        chk("idle_within_bound", (busy || exp_q.size() != 0) ? 1 : 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int mode;
        for (int ch = 0; ch < NUM_CH; ch++) begin mdl_dly[ch] = 0; mdl_en[ch] = 1'b0; end

        repeat (3) @(negedge clk);
        chk("reset_amp_trig", amp_trig, 0);
        chk("reset_busy", busy, 0);
        chk("reset_seq_done", seq_done, 0);
        chk("reset_missed", missed_cnt, 0);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;
        @(negedge clk);
        arm = 1'b1; mdl_arm = 1'b1;

        // Basic two-channel sequence: pulses at E+1 and E+79.
        cfg(0, 0, 1'b1);
        cfg(1, 3, 1'b1);
        fire(e);
        wait_idle(400);
        chk("missed_basic", missed_cnt, 0);

        // Re-trigger 40 cycles into RUN is counted, not scheduled.
        fire(e);
        fire_at(e + 40);
        wait_idle(400);
        chk("missed_retrigger", missed_cnt, mdl_missed);

        // Config change during RUN applies only to the next sequence.
        fire(e);
        repeat (20) @(negedge clk);
        cfg(1, 5, 1'b1);
        wait_idle(400);
        fire(e);
        wait_idle(400);

        // Arm dropped mid-RUN: sequence completes, later trigger ignored.
        fire(e);
        while (cyc < e + 10) @(negedge clk);
        arm = 1'b0; mdl_arm = 1'b0;
        wait_idle(400);
        fire(e);
        repeat (50) @(negedge clk);
        chk("missed_disarmed", missed_cnt, mdl_missed);
        @(negedge clk);
        arm = 1'b1; mdl_arm = 1'b1;
        repeat (2) @(negedge clk);

        // No channel enabled: seq_done alone at E+1.
        cfg(0, 0, 1'b0);
        cfg(1, 5, 1'b0);
        fire(e);
        wait_idle(200);

        // Random configurations with re-triggers around the holdoff boundary.
        for (int it = 0; it < 20; it++) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                cfg(ch, $urandom_range(0, 12), 1'($urandom_range(0, 1)));
            fire(e);
            mode = $urandom_range(0, 3);
            case (mode)
                0: fire_at(cur_be);
                1: fire_at(cur_be + 1);
                2: fire_at(e + $urandom_range(5, cur_be - e));
                default: ;
            endcase
            wait_idle(1000);
            chk("missed_random", missed_cnt, mdl_missed);
        end

        // Saturation: 300 triggers against a long sequence.
        cfg(0, 127, 1'b1);
        for (int ch = 1; ch < NUM_CH; ch++) cfg(ch, 0, 1'b0);
        for (int k = 0; k < 300; k++) fire(e);
        wait_idle(5000);
        chk("missed_saturated", missed_cnt, mdl_missed);
        chk("missed_saturated_255", missed_cnt, 255);

        // Asynchronous reset in the middle of RUN.
        cfg(0, 0, 1'b1);
        cfg(1, 3, 1'b1);
        fire(e);
        while (cyc < e + 30) @(negedge clk);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset_amp_trig", amp_trig, 0);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_missed", missed_cnt, 0);
        chk("midrun_reset_seq_done", seq_done, 0);
        exp_q.delete();
        cur_bs = -10; cur_be = -10; prev_bs = -10; prev_be = -10;
        mdl_missed = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin mdl_dly[ch] = 0; mdl_en[ch] = 1'b0; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        cfg(0, 2, 1'b1);
        cfg(3, 2, 1'b1);
        fire(e);
        wait_idle(400);
        chk("post_reset_missed", missed_cnt, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/amp_trig_sched.md
Name: amp_trig_sched

Overview:
- Multi-channel scheduler for amplifier trigger outputs.
- Takes the machine trigger and, after each rising edge, emits one pulse per enabled channel at a per-channel programmed delay, counted in blocks of BLK_SIZE clocks.
- Owns arming, double-buffered configuration, re-trigger holdoff and missed-trigger accounting.
- Sits between the timing input and the amplifier trigger drivers; configured from the control-register interface.

Parameters:
- NUM_CH, 4: number of trigger output channels.
- BLK_SIZE, 26: clocks per delay unit; 3300 warm-up cycles / 128 steps.
- DLY_W, 7: delay field width; delays 0..127 blocks.
- HOLDOFF_CYC, 64: clocks in HOLDOFF after a sequence completes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trigger_in  in  1  asynchronous machine trigger.
- arm  in  1  level; 1 = accept triggers.
- cfg_wr  in  1  one-cycle write strobe for the shadow config.
- cfg_ch  in  $clog2(NUM_CH)  channel being written.
- cfg_delay  in  DLY_W  delay in blocks.
- cfg_en  in  1  channel enable.
- amp_trig  out  NUM_CH  per-channel trigger pulses.
- busy  out  1  high in RUN or HOLDOFF.
- seq_done  out  1  one-cycle pulse when a sequence ends.
- missed_cnt  out  8  saturating count of triggers ignored while busy.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Shadow and active delays 0; all enables 0.
  - Sync flops 0.
- Input path: trigger_in passes through a 2-FF synchroniser, then a registered rising-edge detect. edge_det is high one cycle, in cycle E.
- Configuration:
  - cfg_wr writes the shadow entry for cfg_ch in any state.
  - cfg_ch >= NUM_CH: write ignored.
  - Shadow is copied to the active set every cycle in IDLE and ARMED, and frozen in RUN and HOLDOFF.
- States:
  - IDLE: arm=1 -> ARMED.
  - ARMED: arm=0 -> IDLE. edge_det=1 -> RUN; blk_ctr and mstr_ctr cleared.
  - RUN:
    - blk_ctr counts 0..BLK_SIZE-1 and wraps.
    - mstr_ctr increments on each wrap.
    - An enabled channel ch pulses amp_trig[ch] for one cycle when mstr_ctr==delay[ch] and blk_ctr==0. Its pulse therefore lands in cycle E+1+delay*BLK_SIZE.
    - After the cycle in which mstr_ctr equals the maximum enabled delay with blk_ctr==0: seq_done=1, go to HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYC cycles, then -> ARMED if arm=1, else IDLE.
- Edge cases:
  - No channel enabled when RUN is entered: seq_done is asserted in cycle E+1 and the block goes to HOLDOFF with no pulses.
  - Several channels with equal delay pulse in the same cycle.
  - arm deasserted during RUN or HOLDOFF: the sequence completes normally, then -> IDLE.
  - edge_det during RUN or HOLDOFF: missed_cnt increments and saturates at 255; missed_cnt is cleared only by reset.
  - A trigger edge in the same cycle HOLDOFF exits is counted as missed.
  - mstr_ctr never exceeds the maximum delay, so there is no wrap-around.
  - Reset mid-RUN: outputs drop immediately (asynchronous assertion). Reset release takes effect on the next clk edge.

Optional Feature:
- AMP_TRIG_STRETCH_EN defined: each amp_trig bit is held high for STRETCH_CYC (4) cycles from the scheduled cycle.
  - Overlapping stretches on one channel cannot occur because delays are unique per channel.
  - A pulse scheduled on the final delay stretches into HOLDOFF, with HOLDOFF_CYC >= STRETCH_CYC enforced by assertion.
- Undefined: pulses are exactly 1 cycle.

Decomposition:
- Package amp_trig_pkg:
  - state enum (IDLE, ARMED, RUN, HOLDOFF).
  - BLK_SIZE_DEF=26, DLY_W_DEF=7, MISSED_W=8, STRETCH_CYC=4.
- One sub-module: trig_sync_edge (2-FF synchroniser plus rising-edge register, rst_n async). Reusable by other trigger inputs.

Test Plan:
- ch0 delay 0, ch1 delay 3, both enabled, arm=1, trigger rising:
  - amp_trig[0] in E+1.
  - amp_trig[1] in E+79.
  - seq_done in E+79.
  - busy low HOLDOFF_CYC cycles later.
- Second trigger at E+40 in the same setup: no extra pulses, missed_cnt=1. Drive 300 such triggers: missed_cnt holds at 255.
- cfg_wr changing ch1 delay to 5 during RUN: the current sequence still fires at delay 3. The next trigger fires at E+131.
- Drop arm at E+10: the sequence completes and the state goes to IDLE after holdoff. A subsequent trigger produces no pulse and does not change missed_cnt.
- All channels disabled, trigger: seq_done at E+1, no amp_trig activity.
- Assert rst_n low at E+30: amp_trig, busy and missed_cnt read 0 immediately. After release, state is IDLE and arm re-enables normally. With AMP_TRIG_STRETCH_EN defined, pulse width is 4 cycles.
